instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline. It holds the PC and a word-organised instruction memory, and drives the IF/ID register (instruction + PC) into instruction_decode. It consumes the jump/redirect, stall and halt signals coming back from ID and the hazard unit. A run-control FSM lets the debug unit load the program before execution starts, and stops fetch once a HALT word is fetched.

Parameters:
MEM_ADDR_WIDTH, 8, log2 of instruction memory depth in 32-bit words (256 words = 1 KiB).
HALT_WORD, 32'hFFFFFFFF, encoding of the HALT instruction.
NOP_WORD, 32'h00000000, encoding injected on flush.

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  leave IDLE and begin fetching at PC=0
i_mem_we  in  1  instruction memory write enable (loader)
i_mem_waddr  in  32  byte address of word to write; bits [1:0] ignored
i_mem_wdata  in  32  instruction word to write
i_stall  in  1  load-use stall from the hazard unit: hold PC and IF/ID
i_halt  in  1  global debug freeze: hold all state
i_jump  in  1  taken jump/branch resolved in ID
i_jump_address  in  32  redirect target from ID
o_instruction  out  32  IF/ID instruction
o_pc  out  32  IF/ID PC (address of o_instruction)
o_running  out  1  FSM in RUN
o_halted  out  1  FSM in HALTED

Behaviour:
- Reset: pc=0, o_instruction=NOP_WORD, o_pc=0, state=IDLE, o_running=0, o_halted=0. Memory contents are not cleared by reset.
- Memory: 2**MEM_ADDR_WIDTH words. Write index = i_mem_waddr[MEM_ADDR_WIDTH+1:2]. Read index = pc[MEM_ADDR_WIDTH+1:2] with combinational read; higher PC bits wrap modulo memory size. Writes are accepted only in IDLE; i_mem_we is ignored in RUN and HALTED.
- FSM states IDLE, RUN, HALTED. IDLE->RUN on i_start. RUN->HALTED when a HALT word is latched into IF/ID. HALTED leaves only on reset. i_start is ignored outside IDLE.
- IDLE: pc held at 0, o_instruction=NOP_WORD, o_pc=0. A write and i_start in the same cycle: the write completes and the first fetch in RUN sees it.
- RUN, per edge, priority highest first:
  1. i_halt: pc, IF/ID and state all hold.
  2. i_stall: pc and IF/ID hold. A simultaneous i_jump is ignored, because ID operands are not valid during a stall.
  3. i_jump: pc<=i_jump_address, o_instruction<=NOP_WORD, o_pc<=0. This flushes the wrong-path word; there is no delay slot.
  4. Normal: o_instruction<=mem[pc], o_pc<=pc, pc<=pc+4 (32-bit, wraps at 2^32).
- Fetch latency: a word at PC p appears on o_instruction exactly one edge after pc==p in a normal cycle.
- HALT: if the normal-path fetched word equals HALT_WORD, it is latched with its PC, pc is not incremented, and state goes to HALTED.
  - A jump in that same cycle wins: flush, no halt.
  - In HALTED, o_instruction/o_pc keep the HALT word while i_stall or i_halt is high. Otherwise the next edge loads NOP_WORD and o_pc=0, and it stays there. pc is frozen.
- Misaligned jump target: bits [1:0] are ignored for the memory index; o_pc carries the full 32-bit value.
- Reset mid-RUN or in HALTED: immediate return to reset values; the loaded program is retained, so i_start reruns it.

Test Plan:
- Load mem[0..3]=0x20010005,0x20020007,0x00221820,0xFFFFFFFF via byte addrs 0,4,8,12, then pulse i_start -> o_instruction/o_pc = (0x20010005,0),(0x20020007,4),(0x00221820,8),(0xFFFFFFFF,12), then NOP with o_halted=1 and pc stuck at 12.
- In RUN with pc=8, i_jump=1, i_jump_address=0x40 -> next edge o_instruction=0, pc=0x40; the following edge o_pc=0x40, o_instruction=mem[16].
- i_stall high 2 cycles while o_pc=4 -> o_instruction/o_pc unchanged for both, then resume with o_pc=8. Same with i_jump=1 during the stall -> jump ignored.
- i_halt high 3 cycles mid-RUN -> all outputs and pc frozen, then resume. In RUN, i_mem_we=1 to addr 0 with 0xDEADBEEF -> mem[0] unchanged (verify after reset+start).
- HALT word at addr 8 while the branch in ID redirects (i_jump=1, target 0x20) in the same cycle -> no halt, o_halted=0, fetch continues from 0x20.
- MEM_ADDR_WIDTH=4, jump to 0x40 -> fetches mem[0] (index wrap) with o_pc=0x40. Reset asserted in HALTED -> o_halted=0, IDLE, program intact on re-start.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage: PC, word-organised instruction memory, IF/ID register and IDLE/RUN/HALTED run control.
// Latency: the word at PC p appears on o_instruction/o_pc one rising edge after pc==p.
// Backpressure: i_halt freezes everything, i_stall holds pc and IF/ID; a jump flushes IF/ID to NOP.
module instruction_fetch #(
  parameter int          MEM_ADDR_WIDTH = 8,
  parameter logic [31:0] HALT_WORD      = 32'hFFFFFFFF,
  parameter logic [31:0] NOP_WORD       = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_waddr,
  input  logic [31:0] i_mem_wdata,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_jump,
  input  logic [31:0] i_jump_address,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_running,
  output logic        o_halted
);

  localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] opc_nxt;

  // Instruction store; contents survive reset so a loaded program can be rerun.
  logic [31:0] mem [MEM_DEPTH];

  logic [MEM_ADDR_WIDTH-1:0] rd_idx;
  logic [MEM_ADDR_WIDTH-1:0] wr_idx;
  logic [31:0]               fetch_word;
  logic                      mem_wr;

  // Byte-offset and above-depth address bits carry no meaning for the index.
  logic unused_waddr_bits;
  assign unused_waddr_bits = ^{i_mem_waddr[31:MEM_ADDR_WIDTH+2], i_mem_waddr[1:0]};

  // Higher PC bits simply wrap modulo the memory depth.
  assign rd_idx     = pc[MEM_ADDR_WIDTH+1:2];
  assign wr_idx     = i_mem_waddr[MEM_ADDR_WIDTH+1:2];
  assign fetch_word = mem[rd_idx];

  // The loader may only write while the core is not executing.
  assign mem_wr = i_mem_we && (state == ST_IDLE) && !i_reset;

  assign o_running = (state == ST_RUN);
  assign o_halted  = (state == ST_HALTED);

  // Loader write port into the instruction memory.
  always_ff @(posedge i_clk) begin
    if (mem_wr) begin
      mem[wr_idx] <= i_mem_wdata;
    end
  end

  // State, PC and IF/ID register update with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      pc            <= '0;
      o_instruction <= NOP_WORD;
      o_pc          <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      o_instruction <= instr_nxt;
      o_pc          <= opc_nxt;
    end
  end

  // Next-state and next IF/ID contents; halt > stall > jump > normal fetch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = o_instruction;
    opc_nxt   = o_pc;
    case (state)
      ST_IDLE: begin
        pc_nxt    = '0;
        instr_nxt = NOP_WORD;
        opc_nxt   = '0;
        if (i_start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Operands in ID are stale during a stall, so a jump then is dropped.
        if (!i_halt && !i_stall) begin
          if (i_jump) begin
            pc_nxt    = i_jump_address;
            instr_nxt = NOP_WORD;
            opc_nxt   = '0;
          end else begin
            instr_nxt = fetch_word;
            opc_nxt   = pc;
            if (fetch_word == HALT_WORD) begin
              state_nxt = ST_HALTED;
            end else begin
              pc_nxt = pc + 32'd4;
            end
          end
        end
      end
      ST_HALTED: begin
        // Keep HALT visible while downstream is frozen, then drain to NOP.
        if (!i_halt && !i_stall) begin
          instr_nxt = NOP_WORD;
          opc_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run scored
// against a cycle-level reference model of two instances (8-bit and 4-bit index).
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [31:0] NOP  = 32'h00000000;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic        i_mem_we;
  logic [31:0] i_mem_waddr;
  logic [31:0] i_mem_wdata;
  logic        i_stall;
  logic        i_halt;
  logic        i_jump;
  logic [31:0] i_jump_address;

  logic [31:0] ins8, pc8, ins4, pc4;
  logic        run8, hlt8, run4, hlt4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = 256-word instance, 1 = 16-word instance.
  logic [31:0] m_mem [2][256];
  logic [31:0] m_pc  [2];
  logic [31:0] m_ins [2];
  logic [31:0] m_opc [2];
  int          m_st  [2];

  instruction_fetch dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_mem_we(i_mem_we), .i_mem_waddr(i_mem_waddr), .i_mem_wdata(i_mem_wdata),
    .i_stall(i_stall), .i_halt(i_halt), .i_jump(i_jump), .i_jump_address(i_jump_address),
    .o_instruction(ins8), .o_pc(pc8), .o_running(run8), .o_halted(hlt8)
  );

  instruction_fetch #(.MEM_ADDR_WIDTH(4)) dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_mem_we(i_mem_we), .i_mem_waddr(i_mem_waddr), .i_mem_wdata(i_mem_wdata),
    .i_stall(i_stall), .i_halt(i_halt), .i_jump(i_jump), .i_jump_address(i_jump_address),
    .o_instruction(ins4), .o_pc(pc4), .o_running(run4), .o_halted(hlt4)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // One clock edge: advance the model with the inputs sampled at that edge.
  task automatic step();
    @(posedge i_clk);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] msk;
      logic [31:0] w;
      msk = (k == 0) ? 32'd255 : 32'd15;
      if (i_reset) begin
        m_st[k] = S_IDLE; m_pc[k] = 0; m_ins[k] = NOP; m_opc[k] = 0;
      end else if (m_st[k] == S_IDLE) begin
        if (i_mem_we) m_mem[k][(i_mem_waddr >> 2) & msk] = i_mem_wdata;
        if (i_start) m_st[k] = S_RUN;
      end else if (m_st[k] == S_RUN) begin
        if (!i_halt && !i_stall) begin
          if (i_jump) begin
            m_pc[k] = i_jump_address; m_ins[k] = NOP; m_opc[k] = 0;
          end else begin
            w = m_mem[k][(m_pc[k] >> 2) & msk];
            m_ins[k] = w;
            m_opc[k] = m_pc[k];
            if (w == HALT) m_st[k] = S_HALT;
            else m_pc[k] = m_pc[k] + 32'd4;
          end
        end
      end else begin
        if (!i_halt && !i_stall) begin
          m_ins[k] = NOP; m_opc[k] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    i_reset = 0; i_start = 0; i_mem_we = 0; i_mem_waddr = 0; i_mem_wdata = 0;
    i_stall = 0; i_halt = 0; i_jump = 0; i_jump_address = 0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    i_mem_we = 1; i_mem_waddr = a; i_mem_wdata = d;
    step();
    i_mem_we = 0;
  endtask

  task automatic do_reset();
    i_reset = 1;
    step();
    i_reset = 0;
  endtask

  task automatic do_start();
    i_start = 1;
    step();
    i_start = 0;
  endtask

  task automatic test_reset();
    logic [31:0] w;
    idle_inputs();
    i_reset = 1;
    step(); step();
    n_checks++; if (ins8 !== NOP)  begin n_fail++; $display("FAIL reset_ins got=%h exp=%h", ins8, NOP); end
    n_checks++; if (pc8 !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc8); end
    n_checks++; if (run8 !== 1'b0) begin n_fail++; $display("FAIL reset_running got=%b exp=0", run8); end
    n_checks++; if (hlt8 !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", hlt8); end
    n_checks++; if (ins4 !== NOP || run4 !== 1'b0) begin n_fail++; $display("FAIL reset_dut4 ins=%h run=%b exp=%h/0", ins4, run4, NOP); end
    i_reset = 0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == HALT) w = 32'h1234_5678;
      load_word(32'(i * 4), w);
    end
    n_checks++; if (run8 !== 1'b0 || ins8 !== NOP || pc8 !== 32'd0) begin
      n_fail++; $display("FAIL idle_hold run=%b ins=%h pc=%h exp=0/%h/0", run8, ins8, pc8, NOP);
    end
  endtask

  task automatic test_program();
    logic [31:0] exp_i [4];
    logic [31:0] exp_p [4];
    exp_i = '{32'h20010005, 32'h20020007, 32'h00221820, 32'hFFFFFFFF};
    exp_p = '{32'd0, 32'd4, 32'd8, 32'd12};
    do_reset();
    load_word(32'd4, 32'h20020007);
    load_word(32'd8, 32'h00221820);
    load_word(32'd12, HALT);
    // Write of word 0 together with start: first fetch must see it.
    i_mem_we = 1; i_mem_waddr = 0; i_mem_wdata = 32'h20010005; i_start = 1;
    step();
    i_mem_we = 0; i_start = 0;
    n_checks++; if (run8 !== 1'b1 || ins8 !== NOP) begin n_fail++; $display("FAIL prog_start run=%b ins=%h exp=1/%h", run8, ins8, NOP); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (ins8 !== exp_i[i]) begin n_fail++; $display("FAIL prog_ins[%0d] got=%h exp=%h", i, ins8, exp_i[i]); end
      n_checks++; if (pc8 !== exp_p[i])  begin n_fail++; $display("FAIL prog_pc[%0d] got=%h exp=%h", i, pc8, exp_p[i]); end
    end
    n_checks++; if (hlt8 !== 1'b1 || run8 !== 1'b0) begin n_fail++; $display("FAIL prog_halted hlt=%b run=%b exp=1/0", hlt8, run8); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (ins8 !== NOP || pc8 !== 32'd0 || hlt8 !== 1'b1) begin
        n_fail++; $display("FAIL prog_drain[%0d] ins=%h pc=%h hlt=%b exp=%h/0/1", i, ins8, pc8, hlt8, NOP);
      end
    end
  endtask

  task automatic test_jump();
    do_reset(); do_start(); step(); step();
    n_checks++; if (pc8 !== 32'd4) begin n_fail++; $display("FAIL jump_pre_pc got=%h exp=4", pc8); end
    i_jump = 1; i_jump_address = 32'h40;
    step();
    i_jump = 0;
    n_checks++; if (ins8 !== NOP || pc8 !== 32'd0) begin n_fail++; $display("FAIL jump_flush ins=%h pc=%h exp=%h/0", ins8, pc8, NOP); end
    step();
    n_checks++; if (pc8 !== 32'h40 || ins8 !== m_mem[0][16]) begin n_fail++; $display("FAIL jump_target pc=%h ins=%h exp=40/%h", pc8, ins8, m_mem[0][16]); end
    step();
    n_checks++; if (pc8 !== 32'h44 || ins8 !== m_mem[0][17]) begin n_fail++; $display("FAIL jump_next pc=%h ins=%h exp=44/%h", pc8, ins8, m_mem[0][17]); end
  endtask

  task automatic test_stall();
    for (int j = 0; j < 2; j++) begin
      do_reset(); do_start(); step(); step();
      i_stall = 1; i_jump = (j == 1); i_jump_address = 32'h80;
      for (int c = 0; c < 2; c++) begin
        step();
        n_checks++; if (pc8 !== 32'd4 || ins8 !== 32'h20020007) begin
          n_fail++; $display("FAIL stall_hold j=%0d c=%0d pc=%h ins=%h exp=4/20020007", j, c, pc8, ins8);
        end
      end
      i_stall = 0; i_jump = 0;
      step();
      n_checks++; if (pc8 !== 32'd8 || ins8 !== 32'h00221820) begin
        n_fail++; $display("FAIL stall_resume j=%0d pc=%h ins=%h exp=8/00221820", j, pc8, ins8);
      end
    end
  endtask

  task automatic test_halt_freeze();
    do_reset(); do_start(); step();
    i_halt = 1; i_jump = 1; i_jump_address = 32'h80;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (pc8 !== 32'd0 || ins8 !== 32'h20010005 || run8 !== 1'b1) begin
        n_fail++; $display("FAIL freeze c=%0d pc=%h ins=%h run=%b exp=0/20010005/1", c, pc8, ins8, run8);
      end
    end
    i_halt = 0; i_jump = 0;
    step();
    n_checks++; if (pc8 !== 32'd4 || ins8 !== 32'h20020007) begin n_fail++; $display("FAIL freeze_resume pc=%h ins=%h exp=4/20020007", pc8, ins8); end
    load_word(32'd0, 32'hDEADBEEF);
    do_reset(); do_start(); step();
    n_checks++; if (ins8 !== 32'h20010005) begin n_fail++; $display("FAIL run_write_ignored got=%h exp=20010005", ins8); end
  endtask

  task automatic test_halt_vs_jump();
    do_reset();
    load_word(32'd8, HALT);
    do_start(); step(); step();
    i_jump = 1; i_jump_address = 32'h20;
    step();
    i_jump = 0;
    n_checks++; if (hlt8 !== 1'b0 || run8 !== 1'b1 || ins8 !== NOP) begin
      n_fail++; $display("FAIL halt_vs_jump hlt=%b run=%b ins=%h exp=0/1/%h", hlt8, run8, ins8, NOP);
    end
    step();
    n_checks++; if (pc8 !== 32'h20 || ins8 !== m_mem[0][8] || hlt8 !== 1'b0) begin
      n_fail++; $display("FAIL halt_vs_jump_next pc=%h ins=%h hlt=%b exp=20/%h/0", pc8, ins8, hlt8, m_mem[0][8]);
    end
    do_reset();
    load_word(32'd8, 32'h00221820);
  endtask

  task automatic test_wrap();
    do_reset(); do_start(); step();
    i_jump = 1; i_jump_address = 32'h40;
    step();
    i_jump = 0;
    step();
    n_checks++; if (ins4 !== 32'h20010005 || pc4 !== 32'h40) begin n_fail++; $display("FAIL wrap4 ins=%h pc=%h exp=20010005/40", ins4, pc4); end
    n_checks++; if (ins8 !== m_mem[0][16]) begin n_fail++; $display("FAIL wrap8 ins=%h exp=%h", ins8, m_mem[0][16]); end
    i_jump = 1; i_jump_address = 32'h41;
    step();
    i_jump = 0;
    step();
    n_checks++; if (pc8 !== 32'h41 || ins8 !== m_mem[0][16]) begin n_fail++; $display("FAIL misalign8 pc=%h ins=%h exp=41/%h", pc8, ins8, m_mem[0][16]); end
    n_checks++; if (pc4 !== 32'h41 || ins4 !== 32'h20010005) begin n_fail++; $display("FAIL misalign4 pc=%h ins=%h exp=41/20010005", pc4, ins4); end
    step();
    n_checks++; if (pc8 !== 32'h45 || ins8 !== m_mem[0][17] || ins4 !== 32'h20020007) begin
      n_fail++; $display("FAIL misalign_next pc=%h ins8=%h ins4=%h exp=45/%h/20020007", pc8, ins8, ins4, m_mem[0][17]);
    end
  endtask

  task automatic test_reset_in_halted();
    do_reset(); do_start();
    for (int c = 0; c < 4; c++) step();
    n_checks++; if (hlt8 !== 1'b1 || ins8 !== HALT || pc8 !== 32'd12) begin
      n_fail++; $display("FAIL halted_entry hlt=%b ins=%h pc=%h exp=1/%h/c", hlt8, ins8, pc8, HALT);
    end
    i_stall = 1;
    step();
    n_checks++; if (ins8 !== HALT || pc8 !== 32'd12) begin n_fail++; $display("FAIL halted_stall ins=%h pc=%h exp=%h/c", ins8, pc8, HALT); end
    i_stall = 0; i_halt = 1;
    step();
    n_checks++; if (ins8 !== HALT || pc8 !== 32'd12) begin n_fail++; $display("FAIL halted_freeze ins=%h pc=%h exp=%h/c", ins8, pc8, HALT); end
    i_halt = 0;
    do_start();
    n_checks++; if (ins8 !== NOP || hlt8 !== 1'b1 || run8 !== 1'b0) begin
      n_fail++; $display("FAIL halted_start_ignored ins=%h hlt=%b run=%b exp=%h/1/0", ins8, hlt8, run8, NOP);
    end
    do_reset();
    n_checks++; if (hlt8 !== 1'b0 || run8 !== 1'b0 || ins8 !== NOP || pc8 !== 32'd0) begin
      n_fail++; $display("FAIL halted_reset hlt=%b run=%b ins=%h pc=%h exp=0/0/%h/0", hlt8, run8, ins8, pc8, NOP);
    end
    do_start(); step();
    n_checks++; if (ins8 !== 32'h20010005 || pc8 !== 32'd0 || run8 !== 1'b1) begin
      n_fail++; $display("FAIL rerun ins=%h pc=%h run=%b exp=20010005/0/1", ins8, pc8, run8);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      i_reset        = ($urandom_range(0, 99) == 0);
      i_start        = ($urandom_range(0, 7) == 0);
      i_mem_we       = ($urandom_range(0, 1) == 0);
      i_mem_waddr    = $urandom;
      i_mem_wdata    = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      i_stall        = ($urandom_range(0, 5) == 0);
      i_halt         = ($urandom_range(0, 7) == 0);
      i_jump         = ($urandom_range(0, 5) == 0);
      i_jump_address = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
      step();
      n_checks++; if (ins8 !== m_ins[0]) begin n_fail++; $display("FAIL rand_ins8 c=%0d got=%h exp=%h", c, ins8, m_ins[0]); end
      n_checks++; if (pc8 !== m_opc[0])  begin n_fail++; $display("FAIL rand_pc8 c=%0d got=%h exp=%h", c, pc8, m_opc[0]); end
      n_checks++; if (run8 !== (m_st[0] == S_RUN))  begin n_fail++; $display("FAIL rand_run8 c=%0d got=%b exp=%b", c, run8, m_st[0] == S_RUN); end
      n_checks++; if (hlt8 !== (m_st[0] == S_HALT)) begin n_fail++; $display("FAIL rand_hlt8 c=%0d got=%b exp=%b", c, hlt8, m_st[0] == S_HALT); end
      n_checks++; if (ins4 !== m_ins[1]) begin n_fail++; $display("FAIL rand_ins4 c=%0d got=%h exp=%h", c, ins4, m_ins[1]); end
      n_checks++; if (pc4 !== m_opc[1])  begin n_fail++; $display("FAIL rand_pc4 c=%0d got=%h exp=%h", c, pc4, m_opc[1]); end
      n_checks++; if (run4 !== (m_st[1] == S_RUN))  begin n_fail++; $display("FAIL rand_run4 c=%0d got=%b exp=%b", c, run4, m_st[1] == S_RUN); end
      n_checks++; if (hlt4 !== (m_st[1] == S_HALT)) begin n_fail++; $display("FAIL rand_hlt4 c=%0d got=%b exp=%b", c, hlt4, m_st[1] == S_HALT); end
    end
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) m_mem[k][i] = 32'd0;
      m_pc[k] = 0; m_ins[k] = NOP; m_opc[k] = 0; m_st[k] = S_IDLE;
    end
    test_reset();
    test_program();
    test_jump();
    test_stall();
    test_halt_freeze();
    test_halt_vs_jump();
    test_wrap();
    test_reset_in_halted();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
